// File: rtl/bp_io_link_arbiter.sv
// Packet-granular round-robin arbiter sharing one wormhole link among
// num_req_p requesters. The grant is locked from header to last body flit.
module bp_io_link_arbiter #(
    parameter int num_req_p    = 4,
    parameter int flit_width_p = 64,
    parameter int len_offset_p = 8,
    parameter int len_width_p  = 4
) (
    input  logic                              clk_i,
    input  logic                              reset_n_i,
    input  logic [num_req_p*flit_width_p-1:0] data_i,
    input  logic [num_req_p-1:0]              v_i,
    output logic [num_req_p-1:0]              ready_and_o,
    output logic [flit_width_p-1:0]           data_o,
    output logic                              v_o,
    input  logic                              ready_and_i,
    output logic [num_req_p-1:0]              grant_o,
    output logic                              busy_o
);

    localparam int          ptr_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;
    localparam int unsigned num_lp   = num_req_p;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        BODY
    } state_t;

    state_t                 state_q, state_d;
    logic [ptr_w_lp-1:0]    rr_q, rr_d;
    logic [ptr_w_lp-1:0]    gnt_q, gnt_d;
    logic [len_width_p-1:0] cnt_q, cnt_d;

    logic                   found;
    logic [ptr_w_lp-1:0]    win;
    logic [ptr_w_lp-1:0]    cand;
    int unsigned            idx;
    logic                   hs;
    logic [len_width_p-1:0] head_len;
    logic [ptr_w_lp-1:0]    next_ptr;

    // Round-robin search: first valid requester at or above rr_q, wrapping to 0
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        cand  = '0;
        for (int unsigned i = 0; i < num_lp; i++) begin
            idx = int'(rr_q) + i;
            if (idx >= num_lp) begin
                idx = idx - num_lp;
            end
            cand = idx[ptr_w_lp-1:0];
            if (!found && v_i[cand]) begin
                found = 1'b1;
                win   = cand;
            end
        end
    end

    // Combinational forwarding of the granted requester onto the link
    always_comb begin
        busy_o      = (state_q != IDLE);
        data_o      = data_i[int'(gnt_q)*flit_width_p +: flit_width_p];
        v_o         = busy_o & v_i[gnt_q];
        ready_and_o = '0;
        grant_o     = '0;
        if (busy_o) begin
            ready_and_o[gnt_q] = ready_and_i;
            grant_o[gnt_q]     = 1'b1;
        end
        hs       = v_o & ready_and_i;
        head_len = data_o[len_offset_p +: len_width_p];
        next_ptr = (gnt_q == ptr_w_lp'(num_req_p - 1)) ? '0 : gnt_q + ptr_w_lp'(1);
    end

    // Next-state logic: grant in IDLE, packet length tracking in HEAD/BODY
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (found) begin
                    gnt_d   = win;
                    state_d = HEAD;
                end
            end
            HEAD: begin
                if (hs) begin
                    if (head_len == '0) begin
                        state_d = IDLE;
                        rr_d    = next_ptr;
                    end else begin
                        state_d = BODY;
                        cnt_d   = head_len;
                    end
                end
            end
            BODY: begin
                if (hs) begin
                    cnt_d = cnt_q - len_width_p'(1);
                    if (cnt_q == len_width_p'(1)) begin
                        state_d = IDLE;
                        rr_d    = next_ptr;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State registers; reset abandons any packet in flight
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q <= IDLE;
            rr_q    <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
